// File: rtl/monitor_and_regulator.sv
// monitor_and_regulator: counts rising edges of two asynchronous ring
// oscillators over fixed 256-cycle windows. The external count drives a
// Fail flag; the internal count drives a bang-bang duty regulator whose
// duty register D sets the width of the PWM supply-control output PSI.
//
// Phase FSM
//   state     | meaning
//   ST_ACCUM  | counting edges inside the current window
//   ST_UPDATE | one cycle after the window end: Fail and D take new values
module monitor_and_regulator (
  input  logic       clk_50MHz,
  input  logic       rst,
  input  logic       RO_internal,
  input  logic       RO_external,
  input  logic [7:0] Fro_min,
  input  logic [7:0] PSI_min,
  input  logic [7:0] PSI_max,
  input  logic [7:0] PSI_set,
  output logic       Fail,
  output logic       PSI
);

  typedef enum logic {
    ST_ACCUM  = 1'b0,
    ST_UPDATE = 1'b1
  } phase_e;

  phase_e     state_q, state_d;

  logic       ext_s1_q, ext_s2_q, ext_prev_q;
  logic       int_s1_q, int_s2_q, int_prev_q;
  logic       ext_rise, int_rise;

  logic [7:0] win_q, win_d;
  logic       win_end;

  logic [7:0] ext_live_q, ext_live_d;
  logic [7:0] int_live_q, int_live_d;
  logic [7:0] ext_cnt_q, ext_cnt_d;
  logic [7:0] int_cnt_q, int_cnt_d;

  logic [7:0] d_q, d_d;
  logic [7:0] d_step, lim_lo, lim_hi;
  logic       fail_q, fail_d;
  logic       psi_q, psi_d;

  // Two-flop synchronizers plus previous-value flops for edge detection
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      ext_s1_q   <= 1'b0;
      ext_s2_q   <= 1'b0;
      ext_prev_q <= 1'b0;
      int_s1_q   <= 1'b0;
      int_s2_q   <= 1'b0;
      int_prev_q <= 1'b0;
    end else begin
      ext_s1_q   <= RO_external;
      ext_s2_q   <= ext_s1_q;
      ext_prev_q <= ext_s2_q;
      int_s1_q   <= RO_internal;
      int_s2_q   <= int_s1_q;
      int_prev_q <= int_s2_q;
    end
  end

  assign ext_rise = ext_s2_q & ~ext_prev_q;
  assign int_rise = int_s2_q & ~int_prev_q;
  assign win_end  = (win_q == 8'd255);

  // Window counter and edge counters; at window end the live counts,
  // including an edge seen in that same cycle, are latched and restarted
  always_comb begin
    win_d      = win_q + 8'd1;
    ext_live_d = ext_live_q + {7'd0, ext_rise};
    int_live_d = int_live_q + {7'd0, int_rise};
    ext_cnt_d  = ext_cnt_q;
    int_cnt_d  = int_cnt_q;
    if (win_end) begin
      ext_cnt_d  = ext_live_q + {7'd0, ext_rise};
      int_cnt_d  = int_live_q + {7'd0, int_rise};
      ext_live_d = 8'd0;
      int_live_d = 8'd0;
    end
  end

  // Phase FSM next state: a single update cycle follows every window end
  always_comb begin
    state_d = ST_ACCUM;
    if (state_q == ST_ACCUM && win_end) begin
      state_d = ST_UPDATE;
    end
  end

  // Regulator step and clamp; limits are reordered so swapped limits behave
  // the same as ordered ones
  always_comb begin
    lim_lo = (PSI_min < PSI_max) ? PSI_min : PSI_max;
    lim_hi = (PSI_min < PSI_max) ? PSI_max : PSI_min;
    d_step = d_q;
    if (int_cnt_q < PSI_set) begin
      d_step = (d_q == 8'd255) ? 8'd255 : d_q + 8'd1;
    end else if (int_cnt_q > PSI_set) begin
      d_step = (d_q == 8'd0) ? 8'd0 : d_q - 8'd1;
    end
    d_d    = d_q;
    fail_d = fail_q;
    if (state_q == ST_UPDATE) begin
      fail_d = (ext_cnt_q < Fro_min);
      if (d_step < lim_lo) begin
        d_d = lim_lo;
      end else if (d_step > lim_hi) begin
        d_d = lim_hi;
      end else begin
        d_d = d_step;
      end
    end
    psi_d = (win_q < d_q);
  end

  // Counter, latch, regulator and output registers
  always_ff @(posedge clk_50MHz) begin
    if (!rst) begin
      state_q    <= ST_ACCUM;
      win_q      <= 8'd0;
      ext_live_q <= 8'd0;
      int_live_q <= 8'd0;
      ext_cnt_q  <= 8'd0;
      int_cnt_q  <= 8'd0;
      d_q        <= 8'd0;
      fail_q     <= 1'b0;
      psi_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      win_q      <= win_d;
      ext_live_q <= ext_live_d;
      int_live_q <= int_live_d;
      ext_cnt_q  <= ext_cnt_d;
      int_cnt_q  <= int_cnt_d;
      d_q        <= d_d;
      fail_q     <= fail_d;
      psi_q      <= psi_d;
    end
  end

  assign Fail = fail_q;
  assign PSI  = psi_q;

endmodule

// File: tb/tb_monitor_and_regulator.sv
// Directed bench for monitor_and_regulator: both ROs run as period-4-clock
// square waves (64 rising edges per window); a model predicts Fail and D
// for each window and pushes them to a scoreboard popped after the update.
`timescale 1ns/1ps
module tb_monitor_and_regulator;

  logic       clk_50MHz;
  logic       rst;
  logic       RO_internal, RO_external;
  logic [7:0] Fro_min, PSI_min, PSI_max, PSI_set;
  logic       Fail, PSI;

  int n_tests = 0;
  int n_fail  = 0;
  int d_model = 0;

  typedef struct {
    logic       fail;
    logic [7:0] d;
  } exp_t;
  exp_t sb[$];

  monitor_and_regulator dut (
    .clk_50MHz  (clk_50MHz),
    .rst        (rst),
    .RO_internal(RO_internal),
    .RO_external(RO_external),
    .Fro_min    (Fro_min),
    .PSI_min    (PSI_min),
    .PSI_max    (PSI_max),
    .PSI_set    (PSI_set),
    .Fail       (Fail),
    .PSI        (PSI)
  );

  initial begin
    clk_50MHz = 1'b0;
    forever #10 clk_50MHz = ~clk_50MHz;
  end

  initial begin
    int c;
    RO_external = 1'b0;
    c = 0;
    forever begin
      @(negedge clk_50MHz);
      c++;
      if (c >= 2) begin
        c = 0;
        RO_external = ~RO_external;
      end
    end
  end

  initial begin
    int c;
    RO_internal = 1'b0;
    c = 1;
    forever begin
      @(negedge clk_50MHz);
      c++;
      if (c >= 2) begin
        c = 0;
        RO_internal = ~RO_internal;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic int step_clamp(int d, int cnt, int set, int a, int b);
    int lo, hi, n;
    lo = (a < b) ? a : b;
    hi = (a < b) ? b : a;
    n  = d;
    if (cnt < set) n = (d == 255) ? 255 : d + 1;
    else if (cnt > set) n = (d == 0) ? 0 : d - 1;
    if (n < lo) n = lo;
    else if (n > hi) n = hi;
    return n;
  endfunction

  // Predict the coming update from the current inputs (64 edges per window)
  task automatic push_expect();
    exp_t e;
    e.fail  = (64 < int'(Fro_min));
    d_model = step_clamp(d_model, 64, int'(PSI_set), int'(PSI_min), int'(PSI_max));
    e.d     = 8'(d_model);
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    e = sb.pop_front();
    chk({tag, "_fail"}, 32'(Fail), 32'(e.fail));
    chk({tag, "_d"}, 32'(dut.d_q), 32'(e.d));
  endtask

  // Called at the negedge just after an update edge; ends at the next one
  task automatic window_check(input string tag);
    push_expect();
    repeat (256) @(negedge clk_50MHz);
    pop_check(tag);
  endtask

  task automatic duty_check(input string tag, input int exp_high);
    int high;
    high = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk_50MHz);
      if (PSI) high++;
    end
    chk(tag, 32'(high), 32'(exp_high));
  endtask

  initial begin
    rst     = 1'b0;
    Fro_min = 8'd0;
    PSI_min = 8'd0;
    PSI_max = 8'd0;
    PSI_set = 8'd0;

    // Reset with ROs toggling
    repeat (3) @(negedge clk_50MHz);
    chk("rst_fail", 32'(Fail), 32'd0);
    chk("rst_psi", 32'(PSI), 32'd0);
    chk("rst_d", 32'(dut.d_q), 32'd0);
    chk("rst_win", 32'(dut.win_q), 32'd0);

    // Release; first window with Fro_min above the 64-edge rate
    Fro_min = 8'd70;
    PSI_set = 8'd100;
    PSI_min = 8'd90;
    PSI_max = 8'd160;
    rst     = 1'b1;
    d_model = 0;
    push_expect();
    repeat (255) @(negedge clk_50MHz);
    chk("win1_cnt255", 32'(dut.win_q), 32'd255);
    @(negedge clk_50MHz);
    chk("fail_hold_pre_update", 32'(Fail), 32'd0);
    @(negedge clk_50MHz);
    pop_check("win1");

    // Fail is not sticky; equality to the threshold does not fail
    Fro_min = 8'd60;
    window_check("fro60");
    Fro_min = 8'd64;
    window_check("fro64");

    // Regulator climbs to the upper limit and holds
    for (int i = 0; i < 70; i++) window_check("up");
    chk("up_model_top", 32'(d_model), 32'd160);
    duty_check("duty160", 160);

    // Swapped limits, regulator down to 90
    PSI_min = 8'd160;
    PSI_max = 8'd90;
    PSI_set = 8'd30;
    for (int i = 0; i < 72; i++) window_check("down");
    duty_check("duty90", 90);

    // Pin D at 120 through the clamp, then hold on equality
    PSI_min = 8'd120;
    PSI_max = 8'd120;
    window_check("pin120");
    PSI_min = 8'd0;
    PSI_max = 8'd255;
    PSI_set = 8'd64;
    for (int i = 0; i < 4; i++) window_check("eq_hold");
    Fro_min = 8'd70;
    window_check("eq_hold_fail");

    // Mid-window reset at window counter 100
    repeat (99) @(negedge clk_50MHz);
    chk("mid_win100", 32'(dut.win_q), 32'd100);
    rst = 1'b0;
    @(negedge clk_50MHz);
    rst = 1'b1;
    chk("mid_rst_fail", 32'(Fail), 32'd0);
    chk("mid_rst_psi", 32'(PSI), 32'd0);
    chk("mid_rst_d", 32'(dut.d_q), 32'd0);
    chk("mid_rst_win", 32'(dut.win_q), 32'd0);
    PSI_set = 8'd200;
    d_model = 0;
    push_expect();
    repeat (255) @(negedge clk_50MHz);
    chk("mid_cnt255", 32'(dut.win_q), 32'd255);
    @(negedge clk_50MHz);
    chk("mid_fail_hold", 32'(Fail), 32'd0);
    @(negedge clk_50MHz);
    pop_check("mid_win1");

    // Fro_min of zero never fails
    Fro_min = 8'd0;
    window_check("fro0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
